// File: rtl/motoro3_line_pwm_ramp_if.sv
// Bundle between the PWM ramp stage and its driver: run controls and slope in,
// segment index, ticks and the PWM pin out.
interface motoro3_line_pwm_ramp_if;
  logic        en;
  logic [7:0]  pwmLen;
  logic [7:0]  pwmMin;
  logic [15:0] lcConst;
  logic [3:0]  lcStep;
  logic        stepTick;
  logic        periodTick;
  logic        pwmOut;
  logic        busy;

  modport master (
    output en, pwmLen, pwmMin, lcConst,
    input  lcStep, stepTick, periodTick, pwmOut, busy
  );

  modport slave (
    input  en, pwmLen, pwmMin, lcConst,
    output lcStep, stepTick, periodTick, pwmOut, busy
  );
endinterface

// File: rtl/motoro3_line_pwm_ramp.sv
// One-phase PWM generator whose duty ramps linearly across a line segment of
// SEG_PERIODS periods; owns the segment index fed back to the line-calc stage.
module motoro3_line_pwm_ramp #(
  parameter int SEG_PERIODS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  motoro3_line_pwm_ramp_if.slave   bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [7:0] SEG_LAST = 8'(SEG_PERIODS - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [7:0]  period_cnt, period_cnt_nxt;
  logic [7:0]  len_reg, len_nxt;
  logic [7:0]  duty_reg, duty_nxt;
  logic [15:0] acc, acc_nxt;
  logic [3:0]  lc_step, lc_step_nxt;
  logic        step_tick, step_tick_nxt;
  logic        period_tick, period_tick_nxt;
  logic        pwm_out, pwm_nxt;
  logic        busy, busy_nxt;

  logic [16:0] acc_sum;
  logic [15:0] acc_sat;
  logic [8:0]  ramp_sum;
  logic [7:0]  ramp_duty, base_duty;
  logic        period_end, seg_end;

  // Slope accumulator saturates instead of wrapping so a steep slope pins the
  // duty at the period length rather than collapsing back to pwmMin.
  assign acc_sum    = {1'b0, acc} + {1'b0, bus.lcConst};
  assign acc_sat    = acc_sum[16] ? 16'hFFFF : acc_sum[15:0];
  assign ramp_sum   = {1'b0, bus.pwmMin} + {1'b0, acc_sat[15:8]};
  assign ramp_duty  = (ramp_sum > {1'b0, bus.pwmLen}) ? bus.pwmLen : ramp_sum[7:0];
  assign base_duty  = (bus.pwmMin > bus.pwmLen) ? bus.pwmLen : bus.pwmMin;
  assign period_end = (len_reg != 8'd0) && (cnt == len_reg - 8'd1);
  assign seg_end    = (period_cnt == SEG_LAST);

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    period_cnt_nxt  = period_cnt;
    len_nxt         = len_reg;
    duty_nxt        = duty_reg;
    acc_nxt         = acc;
    lc_step_nxt     = lc_step;
    step_tick_nxt   = 1'b0;
    period_tick_nxt = 1'b0;
    pwm_nxt         = 1'b0;
    busy_nxt        = 1'b0;
    case (state)
      IDLE: begin
        if (bus.en) begin
          state_nxt      = RUN;
          cnt_nxt        = 8'd0;
          period_cnt_nxt = 8'd0;
          acc_nxt        = 16'd0;
          len_nxt        = bus.pwmLen;
          duty_nxt       = base_duty;
          busy_nxt       = 1'b1;
        end
      end
      RUN: begin
        if (!bus.en) begin
          // lc_step deliberately kept so a restart resumes the same segment
          state_nxt      = IDLE;
          cnt_nxt        = 8'd0;
          period_cnt_nxt = 8'd0;
          acc_nxt        = 16'd0;
        end else if (len_reg == 8'd0) begin
          busy_nxt = 1'b1;
          cnt_nxt  = 8'd0;
          len_nxt  = bus.pwmLen;
        end else begin
          busy_nxt = 1'b1;
          pwm_nxt  = (cnt < duty_reg);
          if (period_end) begin
            cnt_nxt         = 8'd0;
            period_tick_nxt = 1'b1;
            len_nxt         = bus.pwmLen;
            if (seg_end) begin
              period_cnt_nxt = 8'd0;
              acc_nxt        = 16'd0;
              duty_nxt       = base_duty;
              lc_step_nxt    = lc_step + 4'd1;
              step_tick_nxt  = 1'b1;
            end else begin
              period_cnt_nxt = period_cnt + 8'd1;
              acc_nxt        = acc_sat;
              duty_nxt       = ramp_duty;
            end
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      period_cnt  <= 8'd0;
      len_reg     <= 8'd0;
      duty_reg    <= 8'd0;
      acc         <= 16'd0;
      lc_step     <= 4'd0;
      step_tick   <= 1'b0;
      period_tick <= 1'b0;
      pwm_out     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      period_cnt  <= period_cnt_nxt;
      len_reg     <= len_nxt;
      duty_reg    <= duty_nxt;
      acc         <= acc_nxt;
      lc_step     <= lc_step_nxt;
      step_tick   <= step_tick_nxt;
      period_tick <= period_tick_nxt;
      pwm_out     <= pwm_nxt;
      busy        <= busy_nxt;
    end
  end

  assign bus.lcStep     = lc_step;
  assign bus.stepTick   = step_tick;
  assign bus.periodTick = period_tick;
  assign bus.pwmOut     = pwm_out;
  assign bus.busy       = busy;

endmodule

// File: tb/tb_motoro3_line_pwm_ramp.sv
// Bench for the PWM ramp stage: a period-level reference model checked every
// cycle, directed ramp/saturation/wrap/halt/reset scenarios, then random traffic.
module tb_motoro3_line_pwm_ramp;
  localparam int SEG = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  motoro3_line_pwm_ramp_if bus();

  motoro3_line_pwm_ramp #(.SEG_PERIODS(SEG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Reference model: position within the period, ramp value as a plain integer.
  int m_run = 0, m_pos = 0, m_len = 0, m_pc = 0, m_acc = 0, m_duty = 0, m_step = 0;
  int e_pwm = 0, e_busy = 0, e_pt = 0, e_st = 0;

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_len = 0; m_pc = 0; m_acc = 0; m_duty = 0; m_step = 0;
    e_pwm = 0; e_busy = 0; e_pt = 0; e_st = 0;
  endtask

  task automatic model_edge();
    int len_in, min_in, c_in;
    len_in = int'(bus.pwmLen);
    min_in = int'(bus.pwmMin);
    c_in   = int'(bus.lcConst);
    e_pt = 0; e_st = 0; e_pwm = 0;
    if (m_run == 0) begin
      if (bus.en) begin
        m_run = 1; m_pos = 0; m_pc = 0; m_acc = 0;
        m_len = len_in; m_duty = imin(min_in, len_in);
      end
    end else if (!bus.en) begin
      m_run = 0; m_pos = 0; m_pc = 0; m_acc = 0;
    end else if (m_len == 0) begin
      m_pos = 0; m_len = len_in;
    end else begin
      e_pwm = (m_pos < m_duty) ? 1 : 0;
      if (m_pos == m_len - 1) begin
        e_pt = 1; m_pos = 0; m_len = len_in;
        if (m_pc == SEG - 1) begin
          m_pc = 0; m_acc = 0; m_duty = imin(min_in, len_in);
          m_step = (m_step + 1) % 16; e_st = 1;
        end else begin
          m_pc++;
          m_acc  = imin(m_acc + c_in, 65535);
          m_duty = imin(min_in + m_acc / 256, len_in);
        end
      end else begin
        m_pos++;
      end
    end
    e_busy = m_run;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_edge();
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("pwmOut",     int'(bus.pwmOut),     e_pwm);
      chk("busy",       int'(bus.busy),       e_busy);
      chk("periodTick", int'(bus.periodTick), e_pt);
      chk("stepTick",   int'(bus.stepTick),   e_st);
      chk("lcStep",     int'(bus.lcStep),     m_step);
    end
  end

  // Per-period observations: high count, length in samples, stepTick, lcStep.
  int hi_q[$], len_q[$], st_q[$], step_q[$];

  task automatic measure(input int n, input int budget);
    int hi, cyc, got, spent;
    hi = 0; cyc = 0; got = 0; spent = 0;
    hi_q.delete(); len_q.delete(); st_q.delete(); step_q.delete();
    while (got < n && spent < budget) begin
      @(negedge clk);
      spent++; cyc++;
      if (bus.pwmOut) hi++;
      if (bus.periodTick) begin
        hi_q.push_back(hi); len_q.push_back(cyc);
        st_q.push_back(int'(bus.stepTick)); step_q.push_back(int'(bus.lcStep));
        got++; hi = 0; cyc = 0;
      end
    end
    if (got < n) begin
      chk("period_timeout", got, n);
      while (hi_q.size() < n) begin
        hi_q.push_back(-1); len_q.push_back(-1); st_q.push_back(-1); step_q.push_back(-1);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start(input int len, input int mn, input int c);
    @(negedge clk);
    bus.pwmLen = 8'(len); bus.pwmMin = 8'(mn); bus.lcConst = 16'(c);
    bus.en = 1'b1;
  endtask

  initial begin
    int ticks, highs, stc;
    bus.en = 1'b0; bus.pwmLen = 8'd0; bus.pwmMin = 8'd0; bus.lcConst = 16'd0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_pwmOut", int'(bus.pwmOut), 0);
    chk("rst_busy",   int'(bus.busy),   0);
    chk("rst_lcStep", int'(bus.lcStep), 0);
    chk("rst_ticks",  int'(bus.periodTick) + int'(bus.stepTick), 0);
    rst = 1'b0;

    // basic ramp: duty 2,3,5,6 then back to 2
    start(10, 2, 'h0180);
    measure(5, 100);
    chk("ramp_hi0", hi_q[0], 2);
    chk("ramp_hi1", hi_q[1], 3);
    chk("ramp_hi2", hi_q[2], 5);
    chk("ramp_hi3", hi_q[3], 6);
    chk("ramp_hi4", hi_q[4], 2);
    chk("ramp_len1", len_q[1], 10);
    chk("ramp_len4", len_q[4], 10);
    chk("ramp_st2", st_q[2], 0);
    chk("ramp_st3", st_q[3], 1);
    chk("ramp_step2", step_q[2], 0);
    chk("ramp_step3", step_q[3], 1);

    // saturation against period length
    do_reset();
    start(250, 200, 'h4000);
    measure(4, 1100);
    chk("sat_hi0", hi_q[0], 200);
    chk("sat_hi1", hi_q[1], 250);
    chk("sat_hi2", hi_q[2], 250);
    chk("sat_hi3", hi_q[3], 250);

    // accumulator saturation: a wrapping acc would drop the 3rd period to 0
    do_reset();
    start(255, 0, 'h8000);
    measure(4, 1100);
    chk("acc_hi0", hi_q[0], 0);
    chk("acc_hi1", hi_q[1], 128);
    chk("acc_hi2", hi_q[2], 255);
    chk("acc_hi3", hi_q[3], 255);

    // 16 segments of 1-cycle periods: lcStep wraps 15 -> 0
    do_reset();
    start(1, 0, 'h0100);
    measure(64, 300);
    stc = 0;
    foreach (st_q[i]) if (st_q[i] == 1) stc++;
    chk("wrap_ticks", stc, 16);
    chk("wrap_step59", step_q[59], 15);
    chk("wrap_step63", step_q[63], 0);

    // disable mid-segment 2 and resume
    do_reset();
    start(4, 1, 'h0100);
    measure(9, 200);
    chk("dis_step", step_q[8], 2);
    bus.en = 1'b0;
    @(negedge clk);
    chk("dis_busy", int'(bus.busy), 0);
    chk("dis_pwm", int'(bus.pwmOut), 0);
    chk("dis_lcStep", int'(bus.lcStep), 2);
    repeat (3) @(negedge clk);
    bus.en = 1'b1;
    measure(1, 50);
    chk("resume_hi", hi_q[0], 1);
    chk("resume_step", step_q[0], 2);

    // length change and halt
    do_reset();
    start(10, 3, 0);
    measure(1, 50);
    repeat (3) @(negedge clk);
    bus.pwmLen = 8'd6;
    measure(2, 50);
    chk("len_old_rest", len_q[0], 7);
    chk("len_new", len_q[1], 6);
    bus.pwmLen = 8'd0;
    repeat (8) @(negedge clk);
    ticks = 0; highs = 0;
    repeat (30) begin
      @(negedge clk);
      ticks += int'(bus.periodTick);
      highs += int'(bus.pwmOut);
    end
    chk("halt_ticks", ticks, 0);
    chk("halt_pwm", highs, 0);
    bus.pwmLen = 8'd8;
    measure(3, 60);
    chk("unhalt_len1", len_q[1], 8);
    chk("unhalt_len2", len_q[2], 8);

    // random traffic against the model
    do_reset();
    start(7, 2, 'h0200);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) bus.en = ~bus.en;
      if ($urandom_range(0, 59) == 0) begin
        case ($urandom_range(0, 9))
          0:                   bus.pwmLen = 8'd0;
          1, 2, 3, 4, 5, 6:    bus.pwmLen = 8'($urandom_range(1, 12));
          default:             bus.pwmLen = 8'($urandom_range(1, 40));
        endcase
      end
      if ($urandom_range(0, 29) == 0)
        bus.pwmMin = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0)
        bus.lcConst = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 1023));
    end

    // async reset between edges
    do_reset();
    start(2, 1, 0);
    measure(5, 40);
    chk("pre_rst_step", step_q[4], 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_pwm",    int'(bus.pwmOut),     0);
    chk("arst_busy",   int'(bus.busy),       0);
    chk("arst_pt",     int'(bus.periodTick), 0);
    chk("arst_st",     int'(bus.stepTick),   0);
    chk("arst_lcStep", int'(bus.lcStep),     0);
    @(negedge clk);
    bus.en = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
